// File: rtl/csr_pkg.sv
// Shared constants for the performance-counter CSR file: address map,
// CSR op encodings, mcountinhibit bit positions and per-counter lookups.
// Counter slot k: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
package csr_pkg;

   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
   localparam logic [11:0] CSR_MHPMH_BASE    = 12'hB83;
   localparam logic [11:0] CSR_USER_OFFSET   = 12'h100;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

   localparam logic [1:0] CSR_OP_NONE = 2'b00;
   localparam logic [1:0] CSR_OP_RW   = 2'b01;
   localparam logic [1:0] CSR_OP_RS   = 2'b10;
   localparam logic [1:0] CSR_OP_RC   = 2'b11;

   localparam int unsigned INH_CY       = 0;
   localparam int unsigned INH_IR       = 2;
   localparam int unsigned INH_HPM_BASE = 3;

   // Low-half machine address of counter slot k
   function automatic logic [11:0] cnt_lo_addr(input int unsigned k);
      if (k == 0)      return CSR_MCYCLE;
      else if (k == 1) return CSR_MINSTRET;
      else             return CSR_MHPM_BASE + 12'(k - 2);
   endfunction

   // High-half machine address of counter slot k
   function automatic logic [11:0] cnt_hi_addr(input int unsigned k);
      if (k == 0)      return CSR_MCYCLEH;
      else if (k == 1) return CSR_MINSTRETH;
      else             return CSR_MHPMH_BASE + 12'(k - 2);
   endfunction

   // mcountinhibit bit that freezes counter slot k
   function automatic int unsigned cnt_inh_bit(input int unsigned k);
      if (k == 0)      return INH_CY;
      else if (k == 1) return INH_IR;
      else             return INH_HPM_BASE + k - 2;
   endfunction

   // Implemented (writable) bits of mcountinhibit for n HPM counters
   function automatic logic [31:0] inh_mask(input int unsigned n);
      logic [31:0] m;
      m         = '0;
      m[INH_CY] = 1'b1;
      m[INH_IR] = 1'b1;
      for (int unsigned i = 0; i < n; i++) m[INH_HPM_BASE + i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/csr_counter.sv
// One performance counter with half-word CSR write ports.
// Ports: clk_i/reset_i (sync active-high), inc_i event, inhibit_i freeze,
// wrLo_i/wrHi_i half writes of wdata_i, value_o current count.
// A CSR write beats a same-cycle increment; the count wraps silently.
module csr_counter #(
   parameter int unsigned COUNTER_WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     inc_i,
   input  logic                     inhibit_i,
   input  logic                     wrLo_i,
   input  logic                     wrHi_i,
   input  logic [31:0]              wdata_i,
   output logic [COUNTER_WIDTH-1:0] value_o
);

   logic [COUNTER_WIDTH-1:0] value_q, value_d;
   logic [COUNTER_WIDTH-1:0] lo_wr_val, hi_wr_val;

   // Merged write values; a 32-bit counter has no high half to write
   if (COUNTER_WIDTH > 32) begin : g_wide
      assign lo_wr_val = {value_q[COUNTER_WIDTH-1:32], wdata_i};
      assign hi_wr_val = {wdata_i[COUNTER_WIDTH-33:0], value_q[31:0]};
   end else begin : g_narrow
      assign lo_wr_val = wdata_i;
      assign hi_wr_val = value_q;
   end

   // Next count: writes override the increment
   always_comb begin
      value_d = value_q;
      if (inc_i && !inhibit_i) value_d = value_q + COUNTER_WIDTH'(1);
      if (wrLo_i)                                value_d = lo_wr_val;
      else if (wrHi_i && (COUNTER_WIDTH > 32))   value_d = hi_wr_val;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) value_q <= '0;
      else         value_q <= value_d;
   end

   assign value_o = value_q;

endmodule

// File: rtl/csr_counter_file.sv
// Performance-counter CSR file: mcycle, minstret, NUM_HPM mhpmcounters,
// their user read-only shadows and mcountinhibit.
// Ports: clk_i/reset_i (sync active-high); csrValid_i/csrAddr_i/csrOp_i/
// csrWData_i CSR access; csrRData_o old value and csrIllegal_o (both
// combinational); instStep_i retire pulse; hpmEvent_i per-HPM event pulses.
module csr_counter_file
   import csr_pkg::*;
#(
   parameter int unsigned NUM_HPM       = 4,
   parameter int unsigned COUNTER_WIDTH = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               csrValid_i,
   input  logic [11:0]        csrAddr_i,
   input  logic [1:0]         csrOp_i,
   input  logic [31:0]        csrWData_i,
   output logic [31:0]        csrRData_o,
   output logic               csrIllegal_o,
   input  logic               instStep_i,
   input  logic [NUM_HPM-1:0] hpmEvent_i
);

   localparam int unsigned NCNT     = 2 + NUM_HPM;
   localparam logic [31:0] INH_MASK = inh_mask(NUM_HPM);

   logic [31:0]              mcountinhibit_q, mcountinhibit_d;
   logic [COUNTER_WIDTH-1:0] cnt_val [NCNT];
   logic [63:0]              cnt_ext [NCNT];
   logic [NCNT-1:0]          sel_lo, sel_hi, wr_lo, wr_hi;
   logic [11:0]              m_addr;
   logic                     is_user, is_inh, mapped, wr_intent, illegal, we;
   logic [31:0]              old_val, new_val;

   // Address decode, legality, read mux and read-modify-write datapath
   always_comb begin
      is_user = (csrAddr_i[11:8] == 4'hC);
      m_addr  = is_user ? (csrAddr_i - CSR_USER_OFFSET) : csrAddr_i;
      is_inh  = (csrAddr_i == CSR_MCOUNTINHIBIT);
      for (int unsigned k = 0; k < NCNT; k++) begin
         sel_lo[k] = (m_addr == cnt_lo_addr(k));
         sel_hi[k] = (m_addr == cnt_hi_addr(k));
      end
      mapped = is_inh | (|sel_lo) | (|sel_hi);

      // RS/RC with a zero operand is a pure read, so shadows allow it
      wr_intent = (csrOp_i == CSR_OP_RW) |
                  (((csrOp_i == CSR_OP_RS) | (csrOp_i == CSR_OP_RC)) & (|csrWData_i));
      illegal   = csrValid_i & (~mapped | (is_user & wr_intent));
      we        = csrValid_i & ~illegal & wr_intent;

      old_val = '0;
      if (is_inh) old_val = mcountinhibit_q;
      for (int unsigned k = 0; k < NCNT; k++) begin
         if (sel_lo[k]) old_val = cnt_ext[k][31:0];
         if (sel_hi[k]) old_val = cnt_ext[k][63:32];
      end

      case (csrOp_i)
         CSR_OP_RS: new_val = old_val | csrWData_i;
         CSR_OP_RC: new_val = old_val & ~csrWData_i;
         default:   new_val = csrWData_i;
      endcase

      mcountinhibit_d = (we && is_inh) ? (new_val & INH_MASK) : mcountinhibit_q;
      wr_lo           = {NCNT{we}} & sel_lo;
      wr_hi           = {NCNT{we}} & sel_hi;

      csrRData_o   = illegal ? 32'h0 : old_val;
      csrIllegal_o = illegal;
   end

   // Inhibit bits act from the cycle after their write commits
   always_ff @(posedge clk_i) begin
      if (reset_i) mcountinhibit_q <= '0;
      else         mcountinhibit_q <= mcountinhibit_d;
   end

   for (genvar k = 0; k < NCNT; k++) begin : g_cnt
      logic inc;
      if (k == 0) begin : g_cy
         assign inc = 1'b1;
      end else if (k == 1) begin : g_ir
         assign inc = instStep_i;
      end else begin : g_hpm
         assign inc = hpmEvent_i[k-2];
      end

      csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_cnt (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .inc_i     (inc),
         .inhibit_i (mcountinhibit_q[cnt_inh_bit(k)]),
         .wrLo_i    (wr_lo[k]),
         .wrHi_i    (wr_hi[k]),
         .wdata_i   (new_val),
         .value_o   (cnt_val[k])
      );

      assign cnt_ext[k] = 64'(cnt_val[k]);
   end

endmodule

// File: tb/tb_csr_counter_file.sv
// Directed bench for csr_counter_file (NUM_HPM = 4, COUNTER_WIDTH = 64).
// Inputs change just after the falling edge; combinational outputs are
// checked 1 time unit later, commits happen at the following rising edge.
module tb_csr_counter_file;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        csrValid_i;
   logic [11:0] csrAddr_i;
   logic [1:0]  csrOp_i;
   logic [31:0] csrWData_i;
   logic [31:0] csrRData_o;
   logic        csrIllegal_o;
   logic        instStep_i;
   logic [3:0]  hpmEvent_i;

   int checks = 0;
   int errors = 0;

   csr_counter_file #(.NUM_HPM(4), .COUNTER_WIDTH(64)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .csrValid_i   (csrValid_i),
      .csrAddr_i    (csrAddr_i),
      .csrOp_i      (csrOp_i),
      .csrWData_i   (csrWData_i),
      .csrRData_o   (csrRData_o),
      .csrIllegal_o (csrIllegal_o),
      .instStep_i   (instStep_i),
      .hpmEvent_i   (hpmEvent_i)
   );

   always #50 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Legal read (op NONE) with no clock edge consumed
   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csrValid_i = 1'b1;
      csrOp_i    = 2'b00;
      csrAddr_i  = addr;
      csrWData_i = 32'h0;
      #1;
      check(tag, csrRData_o, exp);
      check({tag, "_ill"}, 32'(csrIllegal_o), 32'h0);
   endtask

   // Access that checks old value / illegal flag, then commits over one edge
   task automatic acc(input string tag, input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
      csrValid_i = 1'b1;
      csrOp_i    = op;
      csrAddr_i  = addr;
      csrWData_i = wd;
      #1;
      check(tag, csrRData_o, exp_rd);
      check({tag, "_ill"}, 32'(csrIllegal_o), 32'(exp_ill));
      @(negedge clk_i);
      csrValid_i = 1'b0;
      csrOp_i    = 2'b00;
   endtask

   task automatic cyc(input int n);
      csrValid_i = 1'b0;
      csrOp_i    = 2'b00;
      repeat (n) @(negedge clk_i);
   endtask

   initial begin
      reset_i    = 1'b1;
      csrValid_i = 1'b0;
      csrAddr_i  = 12'h0;
      csrOp_i    = 2'b00;
      csrWData_i = 32'h0;
      instStep_i = 1'b0;
      hpmEvent_i = 4'h0;
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;

      // Reset state
      rd("rst_cycle", 12'hC00, 32'h0);
      rd("rst_inh",   12'h320, 32'h0);
      cyc(10);
      rd("idle_cycle",   12'hC00, 32'd10);
      rd("idle_instret", 12'hC02, 32'h0);
      rd("idle_cycleh",  12'hC80, 32'h0);

      // Carry into the high half
      acc("wr_mcycle_lo", 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'd10, 1'b0);
      acc("wr_mcycle_hi", 2'b01, 12'hB80, 32'h0, 32'h0, 1'b0);
      rd("pre_carry_lo", 12'hC00, 32'hFFFF_FFFF);
      rd("pre_carry_hi", 12'hC80, 32'h0);
      cyc(1);
      rd("carry_hi", 12'hC80, 32'h1);
      rd("carry_lo", 12'hC00, 32'h0);

      // 64-bit wrap
      acc("wr_ones_lo", 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0);
      acc("wr_ones_hi", 2'b01, 12'hB80, 32'hFFFF_FFFF, 32'h1, 1'b0);
      rd("ones_lo", 12'hC00, 32'hFFFF_FFFF);
      rd("ones_hi", 12'hC80, 32'hFFFF_FFFF);
      cyc(1);
      rd("wrap_lo", 12'hC00, 32'h0);
      rd("wrap_hi", 12'hC80, 32'h0);

      // Inhibit: write cycle still counts, later cycles freeze
      instStep_i = 1'b1;
      acc("inh_set", 2'b10, 12'h320, 32'h5, 32'h0, 1'b0);
      rd("inh_cycle0",   12'hB00, 32'h1);
      rd("inh_instret0", 12'hB02, 32'h1);
      rd("inh_readback", 12'h320, 32'h5);
      cyc(3);
      rd("inh_cycle1",   12'hC00, 32'h1);
      rd("inh_instret1", 12'hC02, 32'h1);
      acc("inh_clr_cy", 2'b11, 12'h320, 32'h1, 32'h5, 1'b0);
      rd("inh_after_rc", 12'h320, 32'h4);
      cyc(3);
      rd("cy_resumed",  12'hC00, 32'h4);
      rd("ir_frozen",   12'hC02, 32'h1);
      acc("inh_clr_ir", 2'b11, 12'h320, 32'h4, 32'h4, 1'b0);

      // Collision: write beats same-cycle retire
      acc("collide", 2'b01, 12'hB02, 32'h100, 32'h1, 1'b0);
      instStep_i = 1'b0;
      rd("collide_val", 12'hC02, 32'h100);
      rd("collide_cy",  12'hC00, 32'h6);

      // Illegal accesses
      acc("shadow_rw", 2'b01, 12'hC00, 32'h1234, 32'h0, 1'b1);
      acc("shadow_rs0", 2'b10, 12'hC00, 32'h0, 32'h7, 1'b0);
      acc("unmapped_b1f", 2'b00, 12'hB1F, 32'h0, 32'h0, 1'b1);
      acc("unmapped_b07", 2'b00, 12'hB07, 32'h0, 32'h0, 1'b1);
      acc("unmapped_b01", 2'b01, 12'hB01, 32'hFFFF, 32'h0, 1'b1);
      csrValid_i = 1'b0;
      csrAddr_i  = 12'hB1F;
      #1;
      check("novalid_ill", 32'(csrIllegal_o), 32'h0);
      @(negedge clk_i);
      acc("inh_unimpl", 2'b10, 12'h320, 32'h2, 32'h0, 1'b0);
      rd("inh_unimpl_rb", 12'h320, 32'h0);

      // HPM counters
      acc("wr_hpm3", 2'b01, 12'hB06, 32'hABCD, 32'h0, 1'b0);
      rd("hpm3_val", 12'hC06, 32'hABCD);
      hpmEvent_i = 4'b0010;
      cyc(7);
      hpmEvent_i = 4'b0000;
      rd("hpm1_count", 12'hC04, 32'd7);
      rd("hpm0_count", 12'hC03, 32'h0);
      rd("hpm1_hi",    12'hC84, 32'h0);

      // Reset wins over writes and events
      acc("inh_hpm0", 2'b10, 12'h320, 32'h8, 32'h0, 1'b0);
      hpmEvent_i = 4'b1111;
      instStep_i = 1'b1;
      reset_i    = 1'b1;
      acc("rst_wr", 2'b01, 12'hB04, 32'h55, 32'd7, 1'b0);
      reset_i    = 1'b0;
      hpmEvent_i = 4'b0000;
      instStep_i = 1'b0;
      rd("rst2_hpm1",    12'hC04, 32'h0);
      rd("rst2_cycle",   12'hC00, 32'h0);
      rd("rst2_instret", 12'hC02, 32'h0);
      rd("rst2_hpm3",    12'hC06, 32'h0);
      rd("rst2_inh",     12'h320, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_counter_file.md
Name: csr_counter_file

Overview:
- Parametrised performance-counter CSR file for the pipelined RV32 core; successor to the fixed cycle/instret CSR block.
- Provides mcycle, minstret, NUM_HPM hardware performance counters, their read-only user shadows, and mcountinhibit.
- Supports CSRRW/CSRRS/CSRRC read-modify-write and illegal-access flagging.
- Sits beside the execute stage; read is combinational, write commits at the clock edge.

Parameters:
- NUM_HPM, 4, number of mhpmcounter3.. counters (0..29).
- COUNTER_WIDTH, 64, implemented counter width (32..64); unimplemented upper bits read 0.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- csrValid_i  in  1  CSR instruction in execute this cycle.
- csrAddr_i  in  12  CSR address.
- csrOp_i  in  2  00 none, 01 RW, 10 RS, 11 RC.
- csrWData_i  in  32  rs1/uimm operand.
- csrRData_o  out  32  old CSR value (pre-write).
- csrIllegal_o  out  1  access illegal; raises an exception downstream.
- instStep_i  in  1  one instruction retired this cycle.
- hpmEvent_i  in  NUM_HPM  per-counter event pulse; bit i feeds counter 3+i.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high on reset_i.
- Reset: all counters = 0 and mcountinhibit = 0. Outputs are combinational from state; csrIllegal_o = 0 whenever csrValid_i = 0.
- Address map:
  - Machine: mcycle 0xB00/0xB80, minstret 0xB02/0xB82, mhpmcounter(3+i) 0xB03+i/0xB83+i.
  - User read-only shadows: 0xC00/0xC80, 0xC02/0xC82, 0xC03+i/0xC83+i.
  - mcountinhibit 0x320: bit0 CY, bit2 IR, bit(3+i) HPM i; all other bits read 0 and ignore writes.
- Read: csrRData_o = current value of the addressed half, same cycle, zero latency. Value is 0 if the address is unmapped or the access is illegal.
- Write data:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
- Write enable: csrValid_i & ~illegal & (op == RW, or op ∈ {RS, RC} with wdata != 0). Commits at the next posedge.
- Illegal (combinational, only when csrValid_i = 1):
  - address not in the map, or
  - write-enabled op targeting a 0xCxx shadow.
  - RS/RC with wdata = 0 to a shadow is a legal read.
  - op = 00 with csrValid_i = 1 is a legal read.
  - An illegal access writes nothing.
- Counter update, per counter, every cycle:
  - Increment conditions: cycle increments unconditionally; instret when instStep_i = 1; HPM i when hpmEvent_i[i] = 1. Any counter whose mcountinhibit bit is set holds.
  - Low-half write: replaces bits [31:0] and keeps the upper bits.
  - High-half write: replaces bits [W-1:32] with wdata[W-33:0].
  - If COUNTER_WIDTH = 32, high addresses are legal, read 0, and ignore writes.
  - Collision: a CSR write to either half in the same cycle as an increment wins; that increment is dropped.
  - Wrap: 2^W-1 → 0, no flag.
- Inhibit timing: an mcountinhibit write takes effect from the cycle after it commits. The counter still increments in the write cycle if it was previously enabled.
- Reset mid-operation: reset_i wins over writes and increments in the same cycle.
- Read-after-write: a read in cycle N+1 returns the value committed at the end of cycle N, including that cycle's increment rule.

Decomposition:
- Shared package csr_pkg:
  - address localparams (CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_MHPM_BASE, CSR_MHPMH_BASE, CSR_USER_OFFSET, CSR_MCOUNTINHIBIT);
  - csrOp encodings CSR_OP_NONE/RW/RS/RC;
  - inhibit bit indices.
- Sub-module csr_counter (COUNTER_WIDTH):
  - inputs: inc, inhibit, wrLo, wrHi, wdata;
  - output: value;
  - implements the collision and wrap rules.
  - Instantiated 2+NUM_HPM times via generate.
- Top level holds address decode, RMW datapath, mcountinhibit and read mux.

Test Plan:
- Reset then 10 idle cycles → read 0xC00 returns 10. Read 0xC02 returns 0 with instStep_i = 0.
- Write mcycle: RW 0xB00 wdata 0xFFFFFFFF, RW 0xB80 wdata 0 → increment crosses into the high half; read 0xC80 returns 1 within 2 cycles. With COUNTER_WIDTH = 64 and both halves all-ones, the counter wraps to 0.
- Inhibit: RS 0x320 wdata 0x5 → cycle and instret freeze with instStep_i held 1. Read-back 0x320 = 0x5. RC 0x320 wdata 0x1 → cycle resumes while instret stays frozen.
- Collision: RW 0xB02 wdata 0x100 with instStep_i = 1 in the same cycle → minstret = 0x100 next cycle, not 0x101.
- Illegal:
  - RW 0xC00 → csrIllegal_o = 1, csrRData_o = 0, counter unaffected.
  - RS 0xC00 wdata 0 → legal, returns the count.
  - Address 0xB1F with NUM_HPM = 4 → illegal.
- HPM: pulse hpmEvent_i[1] 7 times → read 0xC04 = 7 and 0xC03 = 0. Assert reset_i during pulses → all counters 0 next cycle.
